range_gen_arbiter: RTL and testbench

Shares one generator instance with the hrange argument set (base, limit, step) among NUM_REQ requesters. Accepts one job at a time and grants jobs in round-robin order. It sequences the generator's _start/_ready/_done handshake and routes each yielded tuple to the owning requester. It sits between requester FSMs and a single hrange-style generator module.

---
 rtl/range_gen_arbiter_pkg.sv | 15 +
 rtl/range_gen_arbiter_rr.sv | 34 +++
 rtl/range_gen_arbiter.sv | 174 +++++++++++++++++
 tb/tb_range_gen_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/range_gen_arbiter_pkg.sv
// range_gen_arbiter_pkg
//   Shared types and constants for the range_gen_arbiter slice.
//   state_t       : arbiter FSM encoding (IDLE, START, RUN)
//   DEFAULT_WIDTH : default signed width of job arguments and yielded values
package range_gen_arbiter_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    START,
    RUN
  } state_t;

endpackage

// File: rtl/range_gen_arbiter_rr.sv
// rr_arbiter
//   Purely combinational round-robin pick: returns the index of the first
//   set bit of req at or after ptr, wrapping around to bit 0.
//   Ports:
//     req       in  N          request vector
//     ptr       in  $clog2(N)  search start position
//     grant_idx out $clog2(N)  selected index (0 when nothing requested)
//     any       out 1          at least one request bit is set
module rr_arbiter #(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  int unsigned idx;

  always_comb begin
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(ptr) + i) % N;
      if (!any && req[IW'(idx)]) begin
        grant_idx = IW'(idx);
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/range_gen_arbiter.sv
// range_gen_arbiter
//   Shares one hrange-style generator (base, limit, step) among NUM_REQ
//   requesters. One job at a time, granted round-robin; the generator's
//   start/ready/done handshake is sequenced here and every yielded tuple is
//   routed to the owning requester.
//   Ports:
//     _clock, _reset                  clock (rising), async active-high reset
//     req_valid/base/limit/step       per-requester job request and arguments
//     req_accept                      one-hot pulse: owner's arguments captured
//     out_ready/out_valid/out_0/out_1 per-requester result stream (shared bus)
//     out_done                        one-hot pulse: owner's job finished
//     busy, owner                     job in flight / current grant holder
//     gen_start/ready/base/limit/step generator control and arguments
//     gen_done/valid/0/1              generator status and yielded tuple
//   Optional: define RANGE_GEN_ARBITER_COUNT_EN to add out_count, the number
//   of transfers in the current job (cleared in START, held after out_done).
module range_gen_arbiter
  import range_gen_arbiter_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  parameter  int unsigned WIDTH   = DEFAULT_WIDTH,
  localparam int unsigned IW      = $clog2(NUM_REQ)
) (
  input  logic                             _clock,
  input  logic                             _reset,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic signed [NUM_REQ*WIDTH-1:0]  req_base,
  input  logic signed [NUM_REQ*WIDTH-1:0]  req_limit,
  input  logic signed [NUM_REQ*WIDTH-1:0]  req_step,
  output logic [NUM_REQ-1:0]               req_accept,
  input  logic [NUM_REQ-1:0]               out_ready,
  output logic [NUM_REQ-1:0]               out_valid,
  output logic signed [WIDTH-1:0]          out_0,
  output logic signed [WIDTH-1:0]          out_1,
  output logic [NUM_REQ-1:0]               out_done,
  output logic                             busy,
  output logic [IW-1:0]                    owner,
  output logic                             gen_start,
  output logic                             gen_ready,
  output logic signed [WIDTH-1:0]          gen_base,
  output logic signed [WIDTH-1:0]          gen_limit,
  output logic signed [WIDTH-1:0]          gen_step,
  input  logic                             gen_done,
  input  logic                             gen_valid,
  input  logic signed [WIDTH-1:0]          gen_0,
  input  logic signed [WIDTH-1:0]          gen_1
`ifdef RANGE_GEN_ARBITER_COUNT_EN
  ,
  output logic [WIDTH-1:0]                 out_count
`endif
);

  state_t               state_q, state_d;
  logic [IW-1:0]        owner_q, owner_d;
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0]     base_q, base_d, limit_q, limit_d, step_q, step_d;
  logic                 busy_q, busy_d;
  logic [NUM_REQ-1:0]   owner_oh;
  logic [IW-1:0]        grant_idx;
  logic                 grant_any;
  logic [WIDTH-1:0]     base_arr  [NUM_REQ];
  logic [WIDTH-1:0]     limit_arr [NUM_REQ];
  logic [WIDTH-1:0]     step_arr  [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign base_arr[g]  = req_base[g*WIDTH +: WIDTH];
    assign limit_arr[g] = req_limit[g*WIDTH +: WIDTH];
    assign step_arr[g]  = req_step[g*WIDTH +: WIDTH];
  end

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  assign owner_oh  = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;
  assign owner     = owner_q;
  assign busy      = busy_q;
  assign gen_base  = base_q;
  assign gen_limit = limit_q;
  assign gen_step  = step_q;

`ifdef RANGE_GEN_ARBITER_COUNT_EN
  logic [WIDTH-1:0] count_q, count_d;
  assign out_count = count_q;
`endif

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    base_d     = base_q;
    limit_d    = limit_q;
    step_d     = step_q;
    req_accept = '0;
    out_valid  = '0;
    out_done   = '0;
    out_0      = '0;
    out_1      = '0;
    gen_start  = 1'b0;
    gen_ready  = 1'b0;
`ifdef RANGE_GEN_ARBITER_COUNT_EN
    count_d    = count_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (grant_any) begin
          owner_d = grant_idx;
          base_d  = base_arr[grant_idx];
          limit_d = limit_arr[grant_idx];
          step_d  = step_arr[grant_idx];
          state_d = START;
        end
      end
      START: begin
        gen_start  = 1'b1;
        req_accept = owner_oh;
`ifdef RANGE_GEN_ARBITER_COUNT_EN
        count_d    = '0;
`endif
        state_d    = RUN;
      end
      RUN: begin
        gen_ready = out_ready[owner_q];
        out_0     = gen_0;
        out_1     = gen_1;
        if (gen_valid && gen_ready) begin
          out_valid = owner_oh;
`ifdef RANGE_GEN_ARBITER_COUNT_EN
          count_d   = count_q + 1'b1;
`endif
        end
        // A transfer on the completion cycle is delivered above as well.
        if (gen_done && gen_ready) begin
          out_done = owner_oh;
          rr_ptr_d = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge _clock or posedge _reset) begin
    if (_reset) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      base_q   <= '0;
      limit_q  <= '0;
      step_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      base_q   <= base_d;
      limit_q  <= limit_d;
      step_q   <= step_d;
      busy_q   <= busy_d;
    end
  end

`ifdef RANGE_GEN_ARBITER_COUNT_EN
  always_ff @(posedge _clock or posedge _reset) begin
    if (_reset) count_q <= '0;
    else        count_q <= count_d;
  end
`endif

endmodule

// File: tb/tb_range_gen_arbiter.sv
module tb_range_gen_arbiter;

  localparam int NR = 4;
  localparam int W  = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NR-1:0]          req_valid = '0;
  logic signed [NR*W-1:0] req_base  = '0, req_limit = '0, req_step = '0;
  logic [NR-1:0]          req_accept, out_valid, out_done;
  logic [NR-1:0]          out_ready = '0;
  logic signed [W-1:0]    out_0, out_1;
  logic                   busy, gen_start, gen_ready, gen_done, gen_valid;
  logic [1:0]             owner;
  logic signed [W-1:0]    gen_base, gen_limit, gen_step, gen_0, gen_1;
`ifdef RANGE_GEN_ARBITER_COUNT_EN
  logic [W-1:0]           out_count;
`endif

  range_gen_arbiter #(.NUM_REQ(NR), .WIDTH(W)) dut (
    ._clock(clk), ._reset(rst),
    .req_valid(req_valid), .req_base(req_base), .req_limit(req_limit), .req_step(req_step),
    .req_accept(req_accept), .out_ready(out_ready), .out_valid(out_valid),
    .out_0(out_0), .out_1(out_1), .out_done(out_done), .busy(busy), .owner(owner),
    .gen_start(gen_start), .gen_ready(gen_ready),
    .gen_base(gen_base), .gen_limit(gen_limit), .gen_step(gen_step),
    .gen_done(gen_done), .gen_valid(gen_valid), .gen_0(gen_0), .gen_1(gen_1)
`ifdef RANGE_GEN_ARBITER_COUNT_EN
    , .out_count(out_count)
`endif
  );

  // Behavioural hrange generator: yields (value, index) for value < limit.
  logic                g_act;
  logic signed [W-1:0] g_cur, g_lim, g_stp;
  logic [W-1:0]        g_idx;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g_act <= 1'b0; g_cur <= '0; g_lim <= '0; g_stp <= '0; g_idx <= '0;
    end else if (gen_start) begin
      g_act <= 1'b1; g_cur <= gen_base; g_lim <= gen_limit; g_stp <= gen_step; g_idx <= '0;
    end else if (g_act && gen_ready) begin
      if (g_cur < g_lim) begin
        g_cur <= g_cur + g_stp; g_idx <= g_idx + 1;
      end else g_act <= 1'b0;
    end
  end
  assign gen_valid = g_act && (g_cur < g_lim);
  assign gen_done  = g_act && !(g_cur < g_lim);
  assign gen_0     = g_cur;
  assign gen_1     = g_idx;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  int ab[NR], al[NR], as_[NR];
  task automatic set_args(input int r, input int b, input int l, input int s);
    ab[r] = b; al[r] = l; as_[r] = s;
    req_base[r*W +: W] = b; req_limit[r*W +: W] = l; req_step[r*W +: W] = s;
  endtask

  int acc_q[$], dacc_q[$], vown_q[$], v0_q[$], v1_q[$];
  int first_acc;
  longint cnt_done;

  function automatic int oh_idx(input logic [NR-1:0] v);
    int r = -1;
    for (int i = 0; i < NR; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Drives requests, samples 1 time unit after each falling edge, and logs
  // accepts / transfers / completions until ndone jobs have finished.
  task automatic serve(input logic [NR-1:0] reqs, input bit hold, input int ndone,
                       input logic [3:0] pat);
    int cyc = 0;
    int nd  = 0;
    int ix;
    acc_q.delete(); dacc_q.delete(); vown_q.delete(); v0_q.delete(); v1_q.delete();
    first_acc = -1; cnt_done = -1;
    req_valid = reqs;
    while (nd < ndone && cyc < 300) begin
      @(negedge clk);
      out_ready = pat[cyc % 4] ? '1 : '0;
      cyc++;
      #1;
      if (req_accept != '0) begin
        ix = oh_idx(req_accept);
        acc_q.push_back(ix); dacc_q.push_back(nd);
        if (first_acc < 0) first_acc = cyc;
        chk("accept_onehot", req_accept, 1 << ix);
        chk("accept_owner", owner, ix);
        chk("start_pulse", gen_start, 1);
        chk("start_ready", gen_ready, 0);
        chk("gen_base", gen_base, ab[ix]);
        chk("gen_limit", gen_limit, al[ix]);
        chk("gen_step", gen_step, as_[ix]);
        if (!hold) req_valid[ix] = 1'b0;
      end
      if (busy && !gen_start) chk("ready_mirror", gen_ready, out_ready[owner]);
      if (out_valid != '0) begin
        chk("valid_onehot", out_valid, 1 << owner);
        vown_q.push_back(int'(owner)); v0_q.push_back(out_0); v1_q.push_back(out_1);
      end
      if (out_done != '0) begin
        chk("done_onehot", out_done, 1 << owner);
        nd++;
`ifdef RANGE_GEN_ARBITER_COUNT_EN
        cnt_done = out_count;
`endif
      end
    end
    if (nd < ndone) chk("serve_timeout", nd, ndone);
    req_valid = '0;
  endtask

  task automatic post_idle();
    @(negedge clk); #1;
    chk("post_busy", busy, 0);
    chk("post_done_pulse", out_done, 0);
    chk("post_valid", out_valid, 0);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [NR-1:0]  req;
    int             b, l, s;
    logic [3:0]     pat;
    int             n;
    logic [4:0][31:0] ev;
  } vec_t;

  function automatic vec_t mk(input logic [NR-1:0] r, input int b, input int l, input int s,
                              input logic [3:0] pat, input int n,
                              input int e0, input int e1, input int e2, input int e3, input int e4);
    vec_t v;
    v.req = r; v.b = b; v.l = l; v.s = s; v.pat = pat; v.n = n;
    v.ev[0] = e0; v.ev[1] = e1; v.ev[2] = e2; v.ev[3] = e3; v.ev[4] = e4;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  vec_t vecs[5];
  int   ex_own[9] = '{1, 1, 1, 1, 1, 2, 2, 2, 2};
  int   ex_val[9] = '{0, 2, 4, 6, 8, 1, 4, 7, 10};
  int   ex_acc[5] = '{0, 1, 2, 3, 0};

  initial begin
    vecs[0] = mk(4'b0001,  1, 11, 3, 4'b1111, 4,  1,  4, 7, 10, 0);
    vecs[1] = mk(4'b0010,  0, 10, 2, 4'b1001, 5,  0,  2, 4,  6, 8);
    vecs[2] = mk(4'b0100,  5,  5, 1, 4'b1111, 0,  0,  0, 0,  0, 0);
    vecs[3] = mk(4'b1000, -4,  2, 2, 4'b1111, 3, -4, -2, 0,  0, 0);
    vecs[4] = mk(4'b0001,  0, 10, 2, 4'b0110, 5,  0,  2, 4,  6, 8);

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_accept", req_accept, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_done", out_done, 0);
    chk("rst_gen_start", gen_start, 0);
    chk("rst_gen_ready", gen_ready, 0);
    chk("rst_gen_base", gen_base, 0);
    chk("rst_out_0", out_0, 0);
`ifdef RANGE_GEN_ARBITER_COUNT_EN
    chk("rst_count", out_count, 0);
`endif
    @(negedge clk); rst = 1'b0;

    // Table of single-requester jobs
    for (int v = 0; v < 5; v++) begin
      int r;
      r = oh_idx(vecs[v].req);
      set_args(r, vecs[v].b, vecs[v].l, vecs[v].s);
      serve(vecs[v].req, 1'b0, 1, vecs[v].pat);
      chk("vec_accepts", acc_q.size(), 1);
      if (acc_q.size() > 0) chk("vec_accept_idx", acc_q[0], r);
      chk("vec_start_latency", first_acc, 1);
      chk("vec_nvals", v0_q.size(), vecs[v].n);
      for (int k = 0; k < v0_q.size() && k < vecs[v].n; k++) begin
        chk("vec_out_0", v0_q[k], $signed(vecs[v].ev[k]));
        chk("vec_out_1", v1_q[k], k);
        chk("vec_owner", vown_q[k], r);
      end
`ifdef RANGE_GEN_ARBITER_COUNT_EN
      chk("vec_count_done", cnt_done, vecs[v].n);
      #1 chk("vec_count_hold", out_count, vecs[v].n);
`endif
      post_idle();
    end

    // Two simultaneous requesters after reset: 1 before 2
    do_reset();
    set_args(1, 0, 10, 2);
    set_args(2, 1, 11, 3);
    serve(4'b0110, 1'b0, 2, 4'b1111);
    chk("pair_accepts", acc_q.size(), 2);
    if (acc_q.size() == 2) begin
      chk("pair_first", acc_q[0], 1);
      chk("pair_second", acc_q[1], 2);
      chk("pair_done_between", dacc_q[1], 1);
    end
    chk("pair_nvals", v0_q.size(), 9);
    for (int k = 0; k < v0_q.size() && k < 9; k++) begin
      chk("pair_owner", vown_q[k], ex_own[k]);
      chk("pair_value", v0_q[k], ex_val[k]);
    end
    post_idle();

    // Reset mid-job
    set_args(0, 0, 10, 2);
    req_valid = 4'b0001;
    begin
      int t = 0;
      while (req_accept == '0 && t < 20) begin @(negedge clk); #1; t++; end
      chk("midrst_accept_seen", req_accept, 4'b0001);
    end
    req_valid = '0;
    repeat (2) @(negedge clk);
    #1 chk("midrst_busy_before", busy, 1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_owner", owner, 0);
    chk("midrst_gen_ready", gen_ready, 0);
    chk("midrst_gen_start", gen_start, 0);
    chk("midrst_gen_base", gen_base, 0);
    chk("midrst_gen_limit", gen_limit, 0);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_done", out_done, 0);
    chk("midrst_out_0", out_0, 0);
    chk("midrst_out_1", out_1, 0);
`ifdef RANGE_GEN_ARBITER_COUNT_EN
    chk("midrst_count", out_count, 0);
`endif
    @(negedge clk); #1 chk("midrst_done_held", out_done, 0);
    rst = 1'b0;
    @(negedge clk); #1 chk("midrst_idle_done", out_done, 0);
    serve(4'b0001, 1'b0, 1, 4'b1111);
    chk("after_rst_nvals", v0_q.size(), 5);
    for (int k = 0; k < v0_q.size() && k < 5; k++) chk("after_rst_value", v0_q[k], 2 * k);
    post_idle();

    // All four requesting continuously
    do_reset();
    set_args(0, 0, 4, 2);
    set_args(1, 10, 13, 1);
    set_args(2, 5, 5, 1);
    set_args(3, 1, 11, 3);
    serve(4'b1111, 1'b1, 5, 4'b1111);
    chk("cont_accepts", acc_q.size(), 5);
    for (int k = 0; k < acc_q.size() && k < 5; k++) begin
      chk("cont_order", acc_q[k], ex_acc[k]);
      chk("cont_done_between", dacc_q[k], k);
    end
    chk("cont_nvals", v0_q.size(), 11);
    post_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
